fp32_scalar: RTL and testbench

Synthesizable constrained-random FP32 stimulus source for the MXINT8 block-conversion datapath. On each randomize strobe it produces one IEEE-754 binary32 word. Mode inputs force the value into a chosen corner class: rounding carry, tie-to-even, mantissa overflow, exponent overflow, NaN/Inf, subnormal, or zero mantissa. It sits in front of the FP32→MXINT8 converter and is driven by a sequencing driver.

---
 rtl/fp32_pkg.sv | 32 +++
 rtl/mxint8_pkg.sv | 13 +
 rtl/lfsr32.sv | 36 +++
 rtl/fp32_scalar.sv | 130 +++++++++++++
 tb/tb_fp32_scalar.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_pkg
//  Description : Shared IEEE-754 binary32 field widths, exponent constants,
//                the packed word layout, and the LFSR step used by the
//                stimulus source.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

   localparam int FP32_WIDTH = 32;
   localparam int EXP_W      = 8;
   localparam int MAN_W      = 23;

   localparam logic [EXP_W-1:0] EXP_NAN      = 8'hFF;
   localparam logic [EXP_W-1:0] EXP_MAX_NORM = 8'hFE;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr32_next(input logic [31:0] cur);
      lfsr32_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mxint8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mxint8_pkg
//  Description : MXINT8 block-format constants shared with the converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mxint8_pkg;

   // Mantissa bits kept by MXINT8 rounding; the guard bit sits just below.
   localparam int KEEP_BITS = 6;

endpackage
`default_nettype wire

// File: rtl/lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr32
//  Description : 32-bit maximal-length Galois LFSR, advanced once per enable.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset, loads seed
//                en    - advance one step on this edge
//                seed  - reset value (zero is replaced by one)
//                state - current LFSR state
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr32
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   logic [31:0] r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         // The all-zero state is a lock-up point of the LFSR.
         r_state <= (seed == 32'h0) ? 32'h1 : seed;
      end else if (en) begin
         r_state <= lfsr32_next(r_state);
      end
   end

   assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/fp32_scalar.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_scalar
//  Description : Constrained-random FP32 stimulus source. Each randomize strobe
//                yields one binary32 word whose fields can be forced into
//                MXINT8 rounding corner classes.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                randomize_i     - generate a new word on this edge
//                sign_i          - sign of the generated word
//                carry_i, tie_i  - force round-up / exact-tie guard+sticky
//                overflow_i      - force kept bits all ones (round to 2.0)
//                scalar_ovf_i    - as overflow_i with exponent 254
//                nan_i           - exponent 255
//                subnormal_i     - exponent 0
//                zero_i          - clear the mantissa last
//                f_o, valid_o    - generated word, one-cycle valid pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module fp32_scalar
   import fp32_pkg::*;
#(
   parameter logic [31:0] SEED      = 32'h1,
   parameter int          KEEP_BITS = mxint8_pkg::KEEP_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        randomize_i,
   input  logic        sign_i,
   input  logic        carry_i,
   input  logic        tie_i,
   input  logic        overflow_i,
   input  logic        scalar_ovf_i,
   input  logic        nan_i,
   input  logic        subnormal_i,
   input  logic        zero_i,
   output logic [31:0] f_o,
   output logic        valid_o
);

   // Guard bit position inside the 23-bit mantissa.
   localparam int G = 22 - KEEP_BITS;

   logic [31:0]          w_state;
   logic [31:0]          w_rnd;
   logic                 w_unused;
   logic [EXP_W-1:0]     w_exp_raw;
   logic [EXP_W-1:0]     w_exp_lim;
   logic [EXP_W-1:0]     w_exp_clamp;
   logic [KEEP_BITS-1:0] w_kept;
   logic [KEEP_BITS-1:0] w_kept_carry;
   logic [G-1:0]         w_sticky_nz;
   fp32_t                w_word;
   fp32_t                r_word;
   logic                 r_valid;

   lfsr32 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (randomize_i),
      .seed  (SEED),
      .state (w_state)
   );

   // Fields are drawn from the state the LFSR is about to take on this edge.
   assign w_rnd    = lfsr32_next(w_state);
   assign w_unused = w_rnd[31];

   always_comb begin
      w_exp_raw    = w_rnd[30:23];
      w_exp_lim    = overflow_i ? (EXP_MAX_NORM - 8'd1) : EXP_MAX_NORM;
      w_exp_clamp  = w_exp_raw;
      if (w_exp_raw == '0) begin
         w_exp_clamp = 8'd1;
      end else if (w_exp_raw > w_exp_lim) begin
         w_exp_clamp = w_exp_lim;
      end

      w_kept       = w_rnd[22:G+1];
      w_kept_carry = w_kept;
      // An all-ones kept field would turn a plain carry into a mantissa overflow.
      if (&w_kept) begin
         w_kept_carry[0] = 1'b0;
      end
      w_sticky_nz    = w_rnd[G-1:0];
      w_sticky_nz[0] = 1'b1;

      w_word.sign = sign_i;

      if (nan_i) begin
         w_word.exp = EXP_NAN;
      end else if (subnormal_i) begin
         w_word.exp = '0;
      end else if (scalar_ovf_i) begin
         w_word.exp = EXP_MAX_NORM;
      end else begin
         w_word.exp = w_exp_clamp;
      end

      if (scalar_ovf_i || overflow_i) begin
         w_word.man = {{KEEP_BITS{1'b1}}, 1'b1, w_sticky_nz};
      end else if (carry_i) begin
         w_word.man = {w_kept_carry, 1'b1, w_sticky_nz};
      end else if (tie_i) begin
         w_word.man = {w_kept, 1'b1, {G{1'b0}}};
      end else begin
         w_word.man = w_rnd[22:0];
      end

      if (zero_i) begin
         w_word.man = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= randomize_i;
         if (randomize_i) begin
            r_word <= w_word;
         end
      end
   end

   assign f_o     = r_word;
   assign valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp32_scalar.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp32_scalar
//  Description : Scoreboard bench for fp32_scalar with a behavioural model of
//                the LFSR sequence and corner-class field rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_scalar;

   localparam int          KB     = 6;
   localparam logic [31:0] SEED_P = 32'h1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        randomize_i = 1'b0;
   logic        sign_i = 1'b0, carry_i = 1'b0, tie_i = 1'b0, overflow_i = 1'b0;
   logic        scalar_ovf_i = 1'b0, nan_i = 1'b0, subnormal_i = 1'b0, zero_i = 1'b0;
   logic [31:0] f_o;
   logic        valid_o;

   always #5 clk = ~clk;

   fp32_scalar #(.SEED(SEED_P), .KEEP_BITS(KB)) dut (
      .clk          (clk),
      .rst          (rst),
      .randomize_i  (randomize_i),
      .sign_i       (sign_i),
      .carry_i      (carry_i),
      .tie_i        (tie_i),
      .overflow_i   (overflow_i),
      .scalar_ovf_i (scalar_ovf_i),
      .nan_i        (nan_i),
      .subnormal_i  (subnormal_i),
      .zero_i       (zero_i),
      .f_o          (f_o),
      .valid_o      (valid_o)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] run_a[$];
   logic [31:0] run_b[$];
   int          rec_sel = 0;
   logic [31:0] model_lfsr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Sequence model: one LFSR step as polynomial arithmetic over GF(2).
   function automatic logic [31:0] step(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 32'h8020_0003;
      return n;
   endfunction

   // Field rules computed with integer arithmetic on the random word.
   function automatic logic [31:0] model_word(input logic [31:0] r, input bit s, input bit c,
         input bit t, input bit o, input bit so, input bit n, input bit sb, input bit z);
      int unsigned e, lim, kept, sticky, man, g, kmax;
      logic [31:0] mv;
      logic [31:0] ev;
      g    = 22 - KB;
      kmax = (1 << KB) - 1;
      e    = (r >> 23) & 255;
      lim  = o ? 253 : 254;
      if (e == 0) e = 1;
      if (e > lim) e = lim;
      if (n) e = 255;
      else if (sb) e = 0;
      else if (so) e = 254;
      kept   = (r >> (g + 1)) & kmax;
      sticky = r & ((1 << g) - 1);
      if (so || o) man = (kmax << (g + 1)) + (1 << g) + (sticky | 1);
      else if (c) begin
         if (kept == kmax) kept = kmax - 1;
         man = (kept << (g + 1)) + (1 << g) + (sticky | 1);
      end else if (t) man = (kept << (g + 1)) + (1 << g);
      else man = r & 32'h007F_FFFF;
      if (z) man = 0;
      mv = man;
      ev = e;
      return {s, ev[7:0], mv[22:0]};
   endfunction

   // Monitor: every valid output consumes one scoreboard entry.
   always @(negedge clk) begin
      if (!rst && valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid actual=%h required=none", f_o);
         end else begin
            check("word", f_o, exp_q.pop_front());
         end
         if (rec_sel == 1) run_a.push_back(f_o);
         if (rec_sel == 2) run_b.push_back(f_o);
      end
   end

   task automatic strobe(input bit s, input bit c, input bit t, input bit o, input bit so,
                         input bit n, input bit sb, input bit z);
      @(negedge clk);
      sign_i = s; carry_i = c; tie_i = t; overflow_i = o; scalar_ovf_i = so;
      nan_i = n; subnormal_i = sb; zero_i = z;
      randomize_i = 1'b1;
      model_lfsr = step(model_lfsr);
      exp_q.push_back(model_word(model_lfsr, s, c, t, o, so, n, sb, z));
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         randomize_i = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      randomize_i = 1'b0;
      @(negedge clk);
      check("reset_f", f_o, 32'h0);
      check("reset_valid", {31'h0, valid_o}, 32'h0);
      model_lfsr = (SEED_P == 32'h0) ? 32'h1 : SEED_P;
      rst = 1'b0;
   endtask

   logic [31:0] held;

   initial begin
      model_lfsr = SEED_P;
      do_reset();

      // Plain random words, sign 0 then 1, recorded for the replay check.
      rec_sel = 1;
      for (int i = 0; i < 40; i++) strobe(i >= 20, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      rec_sel = 0;

      do_reset();
      rec_sel = 2;
      for (int i = 0; i < 40; i++) strobe(i >= 20, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      rec_sel = 0;
      check("replay_len", run_b.size(), run_a.size());
      for (int i = 0; i < run_a.size() && i < run_b.size(); i++)
         check("replay", run_b[i], run_a[i]);

      // Directed corner classes.
      for (int i = 0; i < 4; i++) strobe(i[0], 1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) strobe(i[0], 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) strobe(i[0], 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) strobe(i[0], 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) strobe(i[0], 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) strobe(i[0], 0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 2; i++) strobe(i[0], 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) strobe(i[0], 0, 0, 0, 0, 0, 1, 1);

      // Hold: f_o stays put and valid_o stays low while randomize_i is low.
      @(negedge clk);
      randomize_i = 1'b0;
      carry_i = 1'b0; tie_i = 1'b0; nan_i = 1'b0; zero_i = 1'b0;
      held = f_o;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sign_i = ~sign_i;
         overflow_i = ~overflow_i;
         check("hold_f", f_o, held);
         check("hold_valid", {31'h0, valid_o}, 32'h0);
      end

      // Random mode mixes, with occasional gaps between strobes.
      for (int i = 0; i < 60; i++) begin
         logic [31:0] m;
         m = $urandom;
         strobe(m[0], m[1], m[2], m[3] & m[9], m[4] & m[10], m[5] & m[11],
                m[6] & m[12], m[7]);
         if (m[8] & m[13]) idle(1);
      end
      idle(3);

      check("queue_empty", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
